// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, instruction RAM request handshake and the IF/ID register.
module if_stage #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter logic [15:0] NOP_INST = 16'h0800
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PcTaken,
    input  logic [15:0] PcTarget,
    input  logic        PcStall,
    input  logic        MemConflict,
    output logic        InstReq,
    output logic [15:0] InstAddr,
    input  logic [15:0] InstData,
    input  logic        InstValid,
    output logic [15:0] IdInst,
    output logic [4:0]  IdOp,
    output logic [2:0]  IdRx,
    output logic [2:0]  IdRy,
    output logic [2:0]  IdRz,
    output logic [4:0]  IdFunct,
    output logic [15:0] IdPc,
    output logic        IdValid
);

    localparam int unsigned AW = 16;
    localparam int unsigned IW = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   pc_q, pc_d;
    logic [AW-1:0]   drain_addr_q, drain_addr_d;
    logic [IW-1:0]   hold_inst_q, hold_inst_d;
    logic            hold_full_q, hold_full_d;
    logic [IW-1:0]   id_inst_q, id_inst_d;
    logic [AW-1:0]   id_pc_q, id_pc_d;
    logic            id_valid_q, id_valid_d;

    logic [AW-1:0]   pc_inc;
    logic            accept;
    logic            bubble;

    assign pc_inc = pc_q + AW'(1);

    // Fetch request: a redirect or a full hold buffer suppresses a new request,
    // but an already outstanding request (WAIT/DRAIN) stays asserted.
    always_comb begin
        InstReq  = 1'b0;
        InstAddr = pc_q;
        case (state_q)
            S_FETCH: InstReq = !MemConflict && !hold_full_q && !PcTaken;
            S_WAIT:  InstReq = 1'b1;
            S_DRAIN: begin
                InstReq  = 1'b1;
                InstAddr = drain_addr_q;
            end
            default: InstReq = 1'b0;
        endcase
    end

    // Next-state: redirect first, then response accept, hold-buffer unload and bubbles.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        hold_inst_d  = hold_inst_q;
        hold_full_d  = hold_full_q;
        id_inst_d    = id_inst_q;
        id_pc_d      = id_pc_q;
        id_valid_d   = id_valid_q;
        accept       = 1'b0;
        bubble       = 1'b0;

        if (PcTaken) begin
            pc_d        = PcTarget;
            id_inst_d   = NOP_INST;
            id_valid_d  = 1'b0;
            hold_full_d = 1'b0;
            if ((state_q == S_WAIT || state_q == S_DRAIN) && !InstValid) begin
                state_d = S_DRAIN;
                if (state_q == S_WAIT) begin
                    drain_addr_d = pc_q;
                end
            end else begin
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_IDLE: state_d = S_FETCH;
                S_FETCH: begin
                    if (hold_full_q) begin
                        if (!PcStall) begin
                            id_inst_d   = hold_inst_q;
                            id_pc_d     = pc_q;
                            id_valid_d  = 1'b1;
                            hold_full_d = 1'b0;
                        end
                    end else if (InstReq) begin
                        if (InstValid) begin
                            accept = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                            bubble  = 1'b1;
                        end
                    end else begin
                        bubble = 1'b1;
                    end
                end
                S_WAIT: begin
                    if (InstValid) begin
                        accept = 1'b1;
                    end else begin
                        bubble = 1'b1;
                    end
                end
                S_DRAIN: begin
                    bubble = 1'b1;
                    if (InstValid) begin
                        state_d = S_FETCH;
                    end
                end
                default: state_d = S_IDLE;
            endcase

            if (accept) begin
                pc_d    = pc_inc;
                state_d = S_FETCH;
                if (!PcStall) begin
                    id_inst_d  = InstData;
                    id_pc_d    = pc_inc;
                    id_valid_d = 1'b1;
                end else begin
                    hold_inst_d = InstData;
                    hold_full_d = 1'b1;
                end
            end

            if (bubble && !PcStall) begin
                id_inst_d  = NOP_INST;
                id_valid_d = 1'b0;
            end
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            drain_addr_q <= RESET_PC;
            hold_inst_q  <= NOP_INST;
            hold_full_q  <= 1'b0;
            id_inst_q    <= NOP_INST;
            id_pc_q      <= '0;
            id_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            hold_inst_q  <= hold_inst_d;
            hold_full_q  <= hold_full_d;
            id_inst_q    <= id_inst_d;
            id_pc_q      <= id_pc_d;
            id_valid_q   <= id_valid_d;
        end
    end

    assign IdInst  = id_inst_q;
    assign IdOp    = id_inst_q[15:11];
    assign IdRx    = id_inst_q[10:8];
    assign IdRy    = id_inst_q[7:5];
    assign IdRz    = id_inst_q[4:2];
    assign IdFunct = id_inst_q[4:0];
    assign IdPc    = id_pc_q;
    assign IdValid = id_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a small wait-state instruction RAM model.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        PcTaken;
    logic [15:0] PcTarget;
    logic        PcStall;
    logic        MemConflict;
    logic        InstReq;
    logic [15:0] InstAddr;
    logic [15:0] InstData;
    logic        InstValid;
    logic [15:0] IdInst;
    logic [4:0]  IdOp;
    logic [2:0]  IdRx;
    logic [2:0]  IdRy;
    logic [2:0]  IdRz;
    logic [4:0]  IdFunct;
    logic [15:0] IdPc;
    logic        IdValid;

    int checks = 0;
    int errors = 0;

    logic [7:0] wait_cfg = 8'd0;
    logic [7:0] wcnt = 8'd0;

    always #5 clk = ~clk;

    // RAM: responds once a request has been held for wait_cfg cycles; data = addr + 0x1000.
    assign InstValid = InstReq && (wcnt >= wait_cfg);
    assign InstData  = InstAddr + 16'h1000;
    always @(posedge clk) wcnt <= (InstReq && !InstValid) ? wcnt + 8'd1 : 8'd0;

    if_stage dut (
        .clk(clk), .rst(rst), .PcTaken(PcTaken), .PcTarget(PcTarget),
        .PcStall(PcStall), .MemConflict(MemConflict), .InstReq(InstReq),
        .InstAddr(InstAddr), .InstData(InstData), .InstValid(InstValid),
        .IdInst(IdInst), .IdOp(IdOp), .IdRx(IdRx), .IdRy(IdRy), .IdRz(IdRz),
        .IdFunct(IdFunct), .IdPc(IdPc), .IdValid(IdValid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; PcTaken = 1'b0; PcTarget = 16'h0; PcStall = 1'b0; MemConflict = 1'b0;
        repeat (3) tick();
        checks++; if (IdInst !== 16'h0800) begin errors++; $display("FAIL reset_IdInst got %h exp %h", IdInst, 16'h0800); end
        checks++; if (IdPc !== 16'h0000) begin errors++; $display("FAIL reset_IdPc got %h exp %h", IdPc, 16'h0000); end
        checks++; if (IdValid !== 1'b0) begin errors++; $display("FAIL reset_IdValid got %b exp 0", IdValid); end
        checks++; if (InstReq !== 1'b0) begin errors++; $display("FAIL reset_InstReq got %b exp 0", InstReq); end
        checks++; if (InstAddr !== 16'h0000) begin errors++; $display("FAIL reset_InstAddr got %h exp %h", InstAddr, 16'h0000); end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        #1;
        checks++; if (InstReq !== 1'b0) begin errors++; $display("FAIL idle_InstReq got %b exp 0", InstReq); end
        tick();
        checks++; if (InstReq !== 1'b1) begin errors++; $display("FAIL first_InstReq got %b exp 1", InstReq); end
        checks++; if (InstAddr !== 16'h0000) begin errors++; $display("FAIL first_InstAddr got %h exp 0000", InstAddr); end
        checks++; if (IdValid !== 1'b0) begin errors++; $display("FAIL first_IdValid got %b exp 0", IdValid); end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++; if (IdInst !== 16'h1000 + 16'(k)) begin errors++; $display("FAIL stream_IdInst[%0d] got %h exp %h", k, IdInst, 16'h1000 + 16'(k)); end
            checks++; if (IdPc !== 16'(k + 1)) begin errors++; $display("FAIL stream_IdPc[%0d] got %h exp %h", k, IdPc, 16'(k + 1)); end
            checks++; if (IdValid !== 1'b1) begin errors++; $display("FAIL stream_IdValid[%0d] got %b exp 1", k, IdValid); end
            checks++; if (InstAddr !== 16'(k + 1)) begin errors++; $display("FAIL stream_InstAddr[%0d] got %h exp %h", k, InstAddr, 16'(k + 1)); end
        end
    endtask

    task automatic test_stall();
        tick();
        checks++; if (IdInst !== 16'h1004) begin errors++; $display("FAIL stall_pre_IdInst got %h exp 1004", IdInst); end
        PcStall = 1'b1;
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0005) begin errors++; $display("FAIL stall_req5 got req=%b addr=%h exp req=1 addr=0005", InstReq, InstAddr); end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++; if (IdInst !== 16'h1004 || IdPc !== 16'h0005) begin errors++; $display("FAIL stall_hold[%0d] got inst=%h pc=%h exp inst=1004 pc=0005", k, IdInst, IdPc); end
            checks++; if (InstReq !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got %b exp 0", k, InstReq); end
        end
        tick();
        PcStall = 1'b0;
        #1;
        checks++; if (InstReq !== 1'b0) begin errors++; $display("FAIL unload_noreq got %b exp 0", InstReq); end
        tick();
        checks++; if (IdInst !== 16'h1005 || IdPc !== 16'h0006 || IdValid !== 1'b1) begin errors++; $display("FAIL unload_IdInst got inst=%h pc=%h v=%b exp 1005/0006/1", IdInst, IdPc, IdValid); end
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0006) begin errors++; $display("FAIL resume_addr got req=%b addr=%h exp 1/0006", InstReq, InstAddr); end
    endtask

    task automatic test_conflict();
        repeat (2) tick();
        checks++; if (IdInst !== 16'h1007 || InstAddr !== 16'h0008) begin errors++; $display("FAIL conf_pre got inst=%h addr=%h exp 1007/0008", IdInst, InstAddr); end
        MemConflict = 1'b1;
        #1;
        checks++; if (InstReq !== 1'b0 || InstAddr !== 16'h0008) begin errors++; $display("FAIL conf_noreq got req=%b addr=%h exp 0/0008", InstReq, InstAddr); end
        tick();
        checks++; if (IdInst !== 16'h0800 || IdValid !== 1'b0) begin errors++; $display("FAIL conf_bubble got inst=%h v=%b exp 0800/0", IdInst, IdValid); end
        MemConflict = 1'b0;
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0008) begin errors++; $display("FAIL conf_resume got req=%b addr=%h exp 1/0008", InstReq, InstAddr); end
        tick();
        checks++; if (IdInst !== 16'h1008 || IdPc !== 16'h0009 || IdValid !== 1'b1) begin errors++; $display("FAIL conf_after got inst=%h pc=%h v=%b exp 1008/0009/1", IdInst, IdPc, IdValid); end
    endtask

    task automatic test_redirect_drain();
        PcTaken = 1'b1; PcTarget = 16'h0003;
        tick();
        PcTaken = 1'b0; wait_cfg = 8'd2;
        checks++; if (IdInst !== 16'h0800 || IdValid !== 1'b0) begin errors++; $display("FAIL redir_bubble got inst=%h v=%b exp 0800/0", IdInst, IdValid); end
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0003) begin errors++; $display("FAIL redir_addr got req=%b addr=%h exp 1/0003", InstReq, InstAddr); end
        tick();
        PcTaken = 1'b1; PcTarget = 16'h0040;
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0003) begin errors++; $display("FAIL wait_hold got req=%b addr=%h exp 1/0003", InstReq, InstAddr); end
        tick();
        PcTaken = 1'b0;
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0003 || IdValid !== 1'b0) begin errors++; $display("FAIL drain_old got req=%b addr=%h v=%b exp 1/0003/0", InstReq, InstAddr, IdValid); end
        tick();
        wait_cfg = 8'd0;
        checks++; if (IdInst !== 16'h0800 || IdValid !== 1'b0) begin errors++; $display("FAIL drain_discard got inst=%h v=%b exp 0800/0", IdInst, IdValid); end
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0040) begin errors++; $display("FAIL drain_newpc got req=%b addr=%h exp 1/0040", InstReq, InstAddr); end
        tick();
        checks++; if (IdInst !== 16'h1040 || IdPc !== 16'h0041 || IdValid !== 1'b1) begin errors++; $display("FAIL drain_after got inst=%h pc=%h v=%b exp 1040/0041/1", IdInst, IdPc, IdValid); end
    endtask

    task automatic test_priority();
        PcStall = 1'b1;
        tick();
        checks++; if (IdInst !== 16'h1040 || InstReq !== 1'b0) begin errors++; $display("FAIL prio_hold got inst=%h req=%b exp 1040/0", IdInst, InstReq); end
        PcTaken = 1'b1; PcTarget = 16'h0080; MemConflict = 1'b1;
        #1;
        checks++; if (InstReq !== 1'b0) begin errors++; $display("FAIL prio_noreq got %b exp 0", InstReq); end
        tick();
        checks++; if (IdInst !== 16'h0800 || IdValid !== 1'b0) begin errors++; $display("FAIL prio_nop got inst=%h v=%b exp 0800/0", IdInst, IdValid); end
        PcTaken = 1'b0; PcStall = 1'b0; MemConflict = 1'b0;
        #1;
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0080) begin errors++; $display("FAIL prio_target got req=%b addr=%h exp 1/0080", InstReq, InstAddr); end
        tick();
        checks++; if (IdInst !== 16'h1080 || IdPc !== 16'h0081) begin errors++; $display("FAIL prio_after got inst=%h pc=%h exp 1080/0081", IdInst, IdPc); end
    endtask

    task automatic test_wrap_and_reset();
        PcTaken = 1'b1; PcTarget = 16'hFFFF;
        tick();
        PcTaken = 1'b0;
        #1;
        checks++; if (InstAddr !== 16'hFFFF) begin errors++; $display("FAIL wrap_addr got %h exp ffff", InstAddr); end
        tick();
        checks++; if (IdInst !== 16'h0FFF || IdPc !== 16'h0000) begin errors++; $display("FAIL wrap_id got inst=%h pc=%h exp 0fff/0000", IdInst, IdPc); end
        checks++; if (InstAddr !== 16'h0000) begin errors++; $display("FAIL wrap_next got %h exp 0000", InstAddr); end
        checks++; if (IdOp !== 5'h01 || IdRx !== 3'h7 || IdRy !== 3'h7 || IdRz !== 3'h7 || IdFunct !== 5'h1F) begin errors++; $display("FAIL wrap_fields got op=%h rx=%h ry=%h rz=%h f=%h exp 01/7/7/7/1f", IdOp, IdRx, IdRy, IdRz, IdFunct); end
        tick();
        wait_cfg = 8'd3;
        tick();
        checks++; if (InstReq !== 1'b1 || InstAddr !== 16'h0001 || IdValid !== 1'b0) begin errors++; $display("FAIL wait_state got req=%b addr=%h v=%b exp 1/0001/0", InstReq, InstAddr, IdValid); end
        rst = 1'b0;
        tick();
        checks++; if (InstReq !== 1'b0 || InstAddr !== 16'h0000) begin errors++; $display("FAIL rst_wait_req got req=%b addr=%h exp 0/0000", InstReq, InstAddr); end
        checks++; if (IdInst !== 16'h0800 || IdPc !== 16'h0000 || IdValid !== 1'b0) begin errors++; $display("FAIL rst_wait_id got inst=%h pc=%h v=%b exp 0800/0000/0", IdInst, IdPc, IdValid); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_conflict();
        test_redirect_drain();
        test_priority();
        test_wrap_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 16-bit MIPS16-subset pipeline. It holds the PC, issues fetch requests to instruction RAM, and owns the IF/ID pipeline register whose fields drive the decode/control stage directly. The decode/control stage consumes:
- `IdOp` as the opcode.
- `IdRx`/`IdRy`/`IdRz` as the three register fields.
- `IdFunct` as the sub-function field.

The block handles branch/jump redirection, load-use stalls and structural conflicts with data-memory access to the shared RAM.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `NOP_INST`, 16'h0800, encoding placed in IF/ID for bubbles and flushes (opcode 5'b00001).

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `PcTaken`  in  1  EX stage resolved a taken branch or jump this cycle.
- `PcTarget`  in  16  redirect address, valid when `PcTaken`=1.
- `PcStall`  in  1  hazard unit load-use stall: hold PC and IF/ID.
- `MemConflict`  in  1  MEM stage owns the shared RAM this cycle; no fetch may be issued.
- `InstReq`  out  1  fetch request to instruction RAM.
- `InstAddr`  out  16  fetch address. Stable while a request is outstanding.
- `InstData`  in  16  fetched instruction, valid when `InstValid`=1.
- `InstValid`  in  1  RAM response. May arrive in the same cycle as `InstReq` (zero-wait) or later.
- `IdInst`  out  16  full IF/ID instruction word.
- `IdOp`  out  5  `IdInst[15:11]`.
- `IdRx`  out  3  `IdInst[10:8]`.
- `IdRy`  out  3  `IdInst[7:5]`.
- `IdRz`  out  3  `IdInst[4:2]`.
- `IdFunct`  out  5  `IdInst[4:0]`.
- `IdPc`  out  16  address of the IF/ID instruction plus 1.
- `IdValid`  out  1  IF/ID holds a real instruction; 0 means bubble.

## Operation
- FSM states:
  - IDLE: post-reset; no request.
  - FETCH: request issued with the current PC.
  - WAIT: request outstanding, no response yet.
  - DRAIN: outstanding response must be discarded.
- IDLE→FETCH unconditionally on the first cycle after reset is released.
- FETCH:
  - `InstReq`=!`MemConflict`; `InstAddr`=PC.
  - If `MemConflict`=1: no request is issued and PC is held. IF/ID loads NOP with `IdValid`=0, unless `PcStall`=1, in which case IF/ID holds.
  - If `InstReq`=1 and `InstValid`=0: go to WAIT.
- WAIT: `InstReq`=1, with `InstAddr` held.
- Response accept (`InstValid`=1 in FETCH or WAIT, no redirect):
  - If `PcStall`=0: IF/ID←{`InstData`, PC+1, valid}; PC←PC+1; state←FETCH.
  - If `PcStall`=1: the word goes into a one-entry hold buffer (`HoldFull`←1); PC←PC+1; IF/ID holds.
- Hold buffer:
  - While `HoldFull`=1, no new request is issued (`InstReq`=0).
  - On the first cycle with `PcStall`=0, IF/ID←buffer, `HoldFull`←0, and fetching resumes the next cycle.
- Redirect (`PcTaken`=1):
  - PC←`PcTarget`; IF/ID←NOP with `IdValid`=0; `HoldFull`←0.
  - If a request is outstanding without a response in this cycle: state←DRAIN. Otherwise state←FETCH.
  - `PcTaken` overrides `PcStall` and `MemConflict`.
- DRAIN: `InstReq`=1 at the old address until `InstValid`. The data is discarded, then state←FETCH with the new PC.
- Priority order: `rst` > `PcTaken` > `PcStall` > `MemConflict` > normal fetch.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, and `IdPc` wraps the same way.

## Timing
- Reset values:
  - PC=`RESET_PC`; state=IDLE; `InstReq`=0; `InstAddr`=`RESET_PC`.
  - `IdInst`=`NOP_INST`; `IdPc`=0; `IdValid`=0; `HoldFull`=0.
- Reset asserted mid-request drops the outstanding request without DRAIN. The RAM must tolerate an abandoned request.
- With zero-wait RAM and no hazards: throughput is one instruction per cycle. An instruction at PC=N appears in IF/ID on the edge after the cycle `InstAddr`=N.
- First request: cycle 1 after reset release. First `IdValid`=1: the edge ending that cycle (zero-wait).
- Redirect cost: 1 bubble with zero-wait RAM; 1 plus the remaining wait cycles when DRAIN is entered.
- `Id*` outputs are registered. `InstReq`/`InstAddr` are combinational from state, PC, `MemConflict`, `HoldFull` and `PcTaken`. They do not depend on `InstData`.

## Test plan
- Reset then zero-wait RAM returning `InstData`=addr+16'h1000 → `InstAddr` 0,1,2,3 on consecutive cycles; `IdInst` 16'h1000,16'h1001,…; `IdPc` 1,2,…; `IdValid`=1 from the second cycle.
- `PcStall`=1 for 3 cycles while the response for address 5 arrives → `IdInst` holds the word for address 4. Word 5 is buffered, no request is issued during the stall, `IdInst`=word 5 on the edge after the stall drops, and the next `InstAddr`=6.
- `MemConflict`=1 for 1 cycle at PC=8 → `InstReq`=0 that cycle, `IdInst`=16'h0800 with `IdValid`=0, then fetch resumes at 8.
- `PcTaken`=1, `PcTarget`=16'h0040 at PC=3 with 2-wait RAM outstanding → DRAIN: response for 3 discarded, `IdValid`=0, next request at 16'h0040.
- Simultaneous `PcTaken`, `PcStall` and `MemConflict` → redirect wins: PC=`PcTarget`, IF/ID=NOP, `HoldFull` cleared.
- PC=16'hFFFF fetch → next `InstAddr`=16'h0000, `IdPc`=16'h0000; `rst`=0 while WAIT → all outputs return to reset values on the next edge.
